// File: rtl/store_buffer.sv
// Word-granular store buffer between MEM stage and data memory: FIFO queue of
// committed stores, one drain per idle memory cycle, youngest-match load forwarding.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iStValid,
    input  logic [31:0]      iStAddr,
    input  logic [31:0]      iStData,
    input  logic [31:0]      iStPC,
    output logic             oStReady,
    input  logic [31:0]      iLdAddr,
    output logic             oFwdHit,
    output logic [31:0]      oFwdData,
    input  logic             iMemBusy,
    output logic             oMemWE,
    output logic [31:0]      oMemAddr,
    output logic [31:0]      oMemWData,
    output logic [31:0]      oMemPC,
    output logic [CNT_W-1:0] oCount,
    output logic             oEmpty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [29:0]      entryAddr [DEPTH];
    logic [31:0]      entryData [DEPTH];
    logic [31:0]      entryPc   [DEPTH];
    logic [DEPTH-1:0] entryValid;
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;
    logic [CNT_W-1:0] countReg;
    logic [PTR_W-1:0] ageIdx;
    logic             push;
    logic             drain;
    logic             unusedLowBits;

    // Byte offsets are irrelevant for a word-granular buffer.
    assign unusedLowBits = ^{iStAddr[1:0], iLdAddr[1:0]};

    assign oStReady  = countReg < CNT_W'(DEPTH);
    assign oEmpty    = countReg == '0;
    assign oCount    = countReg;
    assign push      = iStValid && oStReady;
    assign drain     = !oEmpty && !iMemBusy;

    assign oMemWE    = drain;
    assign oMemAddr  = {entryAddr[headPtr], 2'b00};
    assign oMemWData = entryData[headPtr];
    assign oMemPC    = entryPc[headPtr];

    // Walk from oldest (head) to youngest so the last match found wins.
    always_comb begin
        oFwdHit  = 1'b0;
        oFwdData = '0;
        ageIdx   = headPtr;
        for (int i = 0; i < DEPTH; i++) begin
            ageIdx = headPtr + PTR_W'(i);
            if (entryValid[ageIdx] && (entryAddr[ageIdx] == iLdAddr[31:2])) begin
                oFwdHit  = 1'b1;
                oFwdData = entryData[ageIdx];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headPtr    <= '0;
            tailPtr    <= '0;
            countReg   <= '0;
            entryValid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entryAddr[i] <= '0;
                entryData[i] <= '0;
                entryPc[i]   <= '0;
            end
        end else begin
            if (push) begin
                entryAddr[tailPtr]  <= iStAddr[31:2];
                entryData[tailPtr]  <= iStData;
                entryPc[tailPtr]    <= iStPC;
                entryValid[tailPtr] <= 1'b1;
                tailPtr             <= tailPtr + PTR_W'(1);
            end
            // Push never targets the head slot here: that needs empty (no drain) or full (no push).
            if (drain) begin
                entryValid[headPtr] <= 1'b0;
                headPtr             <= headPtr + PTR_W'(1);
            end
            case ({push, drain})
                2'b10:   countReg <= countReg + CNT_W'(1);
                2'b01:   countReg <= countReg - CNT_W'(1);
                default: countReg <= countReg;
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: scenario tasks plus a write scoreboard
// that pops the expected store for every memory write seen.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } wr_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             iStValid = 1'b0;
    logic [31:0]      iStAddr = '0;
    logic [31:0]      iStData = '0;
    logic [31:0]      iStPC = '0;
    logic             oStReady;
    logic [31:0]      iLdAddr = '0;
    logic             oFwdHit;
    logic [31:0]      oFwdData;
    logic             iMemBusy = 1'b0;
    logic             oMemWE;
    logic [31:0]      oMemAddr;
    logic [31:0]      oMemWData;
    logic [31:0]      oMemPC;
    logic [CNT_W-1:0] oCount;
    logic             oEmpty;

    wr_t expQ[$];
    wr_t monExp;
    int  nCompared = 0;
    int  nMismatch = 0;

    store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .iStValid(iStValid), .iStAddr(iStAddr), .iStData(iStData), .iStPC(iStPC),
        .oStReady(oStReady),
        .iLdAddr(iLdAddr), .oFwdHit(oFwdHit), .oFwdData(oFwdData),
        .iMemBusy(iMemBusy),
        .oMemWE(oMemWE), .oMemAddr(oMemAddr), .oMemWData(oMemWData), .oMemPC(oMemPC),
        .oCount(oCount), .oEmpty(oEmpty)
    );

    always #5 clk = ~clk;

    // Write scoreboard: a write seen at negedge commits at the next rising edge.
    always @(negedge clk) begin
        if (!reset && oMemWE) begin
            nCompared++;
            if (expQ.size() == 0) begin
                nMismatch++;
                $display("FAIL mem_write_unexpected: got addr=%h data=%h pc=%h, required no write",
                         oMemAddr, oMemWData, oMemPC);
            end else begin
                monExp = expQ.pop_front();
                if ({oMemAddr, oMemWData, oMemPC} !== monExp) begin
                    nMismatch++;
                    $display("FAIL mem_write_order: got addr=%h data=%h pc=%h, required addr=%h data=%h pc=%h",
                             oMemAddr, oMemWData, oMemPC, monExp.addr, monExp.data, monExp.pc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveStore(input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] p, input bit accepted);
        iStValid = 1'b1;
        iStAddr  = a;
        iStData  = d;
        iStPC    = p;
        if (accepted) expQ.push_back('{addr: {a[31:2], 2'b00}, data: d, pc: p});
    endtask

    task automatic waitEmpty(output bit ok);
        int cyc;
        cyc = 0;
        while (oEmpty !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        ok = (oEmpty === 1'b1);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        @(negedge clk);
        nCompared++;
        if ({oEmpty, oStReady, oMemWE, oFwdHit} !== 4'b1100) begin
            nMismatch++;
            $display("FAIL reset_flags: got empty/ready/we/hit=%b, required 1100",
                     {oEmpty, oStReady, oMemWE, oFwdHit});
        end
        nCompared++;
        if (oCount !== '0) begin
            nMismatch++;
            $display("FAIL reset_count: got %0d, required 0", oCount);
        end
        nCompared++;
        if (oFwdData !== 32'h0) begin
            nMismatch++;
            $display("FAIL reset_fwd_data: got %h, required 0", oFwdData);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single();
        iMemBusy = 1'b0;
        driveStore(32'h10, 32'hDEAD_BEEF, 32'h100, 1'b1);
        tick();
        iStValid = 1'b0;
        iLdAddr  = 32'h10;
        @(negedge clk);
        nCompared++;
        if ({oMemWE, oMemAddr, oMemWData} !== {1'b1, 32'h10, 32'hDEAD_BEEF}) begin
            nMismatch++;
            $display("FAIL single_drain: got we=%b addr=%h data=%h, required we=1 addr=10 data=deadbeef",
                     oMemWE, oMemAddr, oMemWData);
        end
        nCompared++;
        if ({oFwdHit, oFwdData} !== {1'b1, 32'hDEAD_BEEF}) begin
            nMismatch++;
            $display("FAIL single_fwd_draining_head: got hit=%b data=%h, required hit=1 data=deadbeef",
                     oFwdHit, oFwdData);
        end
        tick();
        @(negedge clk);
        nCompared++;
        if ({oEmpty, oMemWE, oFwdHit} !== 3'b100) begin
            nMismatch++;
            $display("FAIL single_empty_after: got empty/we/hit=%b, required 100", {oEmpty, oMemWE, oFwdHit});
        end
    endtask

    task automatic test_fill();
        bit ok;
        iMemBusy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            driveStore(32'(4 * i), 32'(i + 1), 32'h1000 + 32'(4 * i), 1'b1);
            tick();
        end
        iStValid = 1'b0;
        @(negedge clk);
        nCompared++;
        if ({oCount, oStReady, oMemWE} !== {3'd4, 1'b0, 1'b0}) begin
            nMismatch++;
            $display("FAIL fill_full: got count=%0d ready=%b we=%b, required count=4 ready=0 we=0",
                     oCount, oStReady, oMemWE);
        end
        tick();
        driveStore(32'h40, 32'h5, 32'h1010, 1'b0);
        tick();
        iStValid = 1'b0;
        @(negedge clk);
        nCompared++;
        if (oCount !== 3'd4) begin
            nMismatch++;
            $display("FAIL fill_reject_fifth: got count=%0d, required 4", oCount);
        end
        tick();
        iMemBusy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            nCompared++;
            if ({oMemWE, oMemWData} !== {1'b1, 32'(k + 1)}) begin
                nMismatch++;
                $display("FAIL fill_drain_seq%0d: got we=%b data=%h, required we=1 data=%h",
                         k, oMemWE, oMemWData, k + 1);
            end
            tick();
        end
        waitEmpty(ok);
        nCompared++;
        if (!ok || expQ.size() != 0) begin
            nMismatch++;
            $display("FAIL fill_all_drained: got empty=%b pending=%0d, required empty=1 pending=0",
                     oEmpty, expQ.size());
        end
    endtask

    task automatic test_forward();
        bit ok;
        iMemBusy = 1'b1;
        driveStore(32'h30, 32'hC, 32'h2000, 1'b1); tick();
        driveStore(32'h34, 32'hE, 32'h2004, 1'b1); tick();
        driveStore(32'h20, 32'hA, 32'h2008, 1'b1); tick();
        driveStore(32'h20, 32'hB, 32'h200C, 1'b1);
        iLdAddr = 32'h20;
        @(negedge clk);
        nCompared++;
        if ({oFwdHit, oFwdData} !== {1'b1, 32'hA}) begin
            nMismatch++;
            $display("FAIL fwd_push_invisible: got hit=%b data=%h, required hit=1 data=a", oFwdHit, oFwdData);
        end
        tick();
        iStValid = 1'b0;
        iLdAddr  = 32'h22;
        #1;
        nCompared++;
        if ({oFwdHit, oFwdData} !== {1'b1, 32'hB}) begin
            nMismatch++;
            $display("FAIL fwd_youngest: got hit=%b data=%h, required hit=1 data=b", oFwdHit, oFwdData);
        end
        iLdAddr = 32'h24;
        #1;
        nCompared++;
        if ({oFwdHit, oFwdData} !== {1'b0, 32'h0}) begin
            nMismatch++;
            $display("FAIL fwd_miss: got hit=%b data=%h, required hit=0 data=0", oFwdHit, oFwdData);
        end
        iLdAddr = 32'h33;
        #1;
        nCompared++;
        if ({oFwdHit, oFwdData} !== {1'b1, 32'hC}) begin
            nMismatch++;
            $display("FAIL fwd_oldest: got hit=%b data=%h, required hit=1 data=c", oFwdHit, oFwdData);
        end
        tick();
        iMemBusy = 1'b0;
        waitEmpty(ok);
        iLdAddr = 32'h20;
        #1;
        nCompared++;
        if (!ok || oFwdHit !== 1'b0 || expQ.size() != 0) begin
            nMismatch++;
            $display("FAIL fwd_drained: got empty=%b hit=%b pending=%0d, required empty=1 hit=0 pending=0",
                     oEmpty, oFwdHit, expQ.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        iMemBusy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            driveStore(32'h200 + 32'(4 * i), 32'h100 + 32'(i), 32'h3000 + 32'(i), 1'b1);
            tick();
        end
        iMemBusy = 1'b0;
        for (int i = 2; i < 12; i++) begin
            driveStore(32'h200 + 32'(4 * i) + 32'(i % 4), 32'h100 + 32'(i), 32'h3000 + 32'(i), 1'b1);
            @(negedge clk);
            nCompared++;
            if ({oCount, oMemWE, oStReady} !== {3'd2, 1'b1, 1'b1}) begin
                nMismatch++;
                $display("FAIL b2b_cycle%0d: got count=%0d we=%b ready=%b, required count=2 we=1 ready=1",
                         i, oCount, oMemWE, oStReady);
            end
            tick();
        end
        iStValid = 1'b0;
        #1;
        nCompared++;
        if (oCount !== 3'd2) begin
            nMismatch++;
            $display("FAIL b2b_count_end: got %0d, required 2", oCount);
        end
        waitEmpty(ok);
        nCompared++;
        if (!ok || expQ.size() != 0) begin
            nMismatch++;
            $display("FAIL b2b_drained: got empty=%b pending=%0d, required empty=1 pending=0",
                     oEmpty, expQ.size());
        end
    endtask

    task automatic test_reset_mid();
        iMemBusy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            driveStore(32'h400 + 32'(4 * i), 32'h55 + 32'(i), 32'h4000 + 32'(i), 1'b1);
            tick();
        end
        iStValid = 1'b0;
        iLdAddr  = 32'h400;
        iMemBusy = 1'b0;
        #1;
        nCompared++;
        if ({oMemWE, oCount} !== {1'b1, 3'd3}) begin
            nMismatch++;
            $display("FAIL rstmid_before: got we=%b count=%0d, required we=1 count=3", oMemWE, oCount);
        end
        reset = 1'b1;
        #1;
        expQ.delete();
        nCompared++;
        if ({oMemWE, oEmpty, oFwdHit, oCount} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
            nMismatch++;
            $display("FAIL rstmid_immediate: got we=%b empty=%b hit=%b count=%0d, required we=0 empty=1 hit=0 count=0",
                     oMemWE, oEmpty, oFwdHit, oCount);
        end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            nCompared++;
            if ({oMemWE, oEmpty} !== 2'b01) begin
                nMismatch++;
                $display("FAIL rstmid_no_write%0d: got we=%b empty=%b, required we=0 empty=1", k, oMemWE, oEmpty);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_forward();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
